// File: rtl/flag_unit_if.sv
// Bus bundle for the condition-flag unit: ALU and stack controls in, flags and status out.
interface flag_unit_if #(
    parameter int WIDTH       = 16,
    parameter int STACK_DEPTH = 4
);
    localparam int DW = $clog2(STACK_DEPTH + 1);

    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [WIDTH:0]   result;
    logic [1:0]       mode;
    logic             upd;
    logic [3:0]       mask;
    logic             wr_en;
    logic [3:0]       wr_flags;
    logic             push;
    logic             pop;
    logic             err_clr;
    logic [3:0]       cond;
    logic             C;
    logic             Z;
    logic             N;
    logic             O;
    logic             cond_true;
    logic [DW-1:0]    depth;
    logic             full;
    logic             empty;
    logic             stack_err;

    modport master (
        output op1, op2, result, mode, upd, mask, wr_en, wr_flags,
        output push, pop, err_clr, cond,
        input  C, Z, N, O, cond_true, depth, full, empty, stack_err
    );

    modport slave (
        input  op1, op2, result, mode, upd, mask, wr_en, wr_flags,
        input  push, pop, err_clr, cond,
        output C, Z, N, O, cond_true, depth, full, empty, stack_err
    );
endinterface

// File: rtl/flag_unit.sv
// Registered C/Z/N/O flag unit with masked ALU update, direct write,
// a LIFO save/restore stack and a branch-condition evaluator.
module flag_unit #(
    parameter int WIDTH       = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    flag_unit_if.slave  bus
);
    localparam int DW = $clog2(STACK_DEPTH + 1);

    localparam logic [1:0] MODE_NONE  = 2'b00;
    localparam logic [1:0] MODE_ADD   = 2'b01;
    localparam logic [1:0] MODE_SUB   = 2'b10;
    localparam logic [1:0] MODE_LOGIC = 2'b11;

    // Flag vectors are ordered {C,Z,N,O} everywhere.
    logic [3:0]    flags_reg;
    logic [3:0]    flags_next;
    logic [3:0]    alu_flags;
    logic [3:0]    alu_merged;
    logic [3:0]    stack_top;
    logic [3:0]    entries [STACK_DEPTH];
    logic [DW-1:0] depth_reg;
    logic [DW-1:0] depth_next;
    logic          stack_err_reg;
    logic          stack_err_next;
    logic          is_full;
    logic          is_empty;
    logic          push_ok;
    logic          pop_ok;
    logic          err_event;
    logic          alu_valid;
    logic          cond_true_c;
    logic          sgn_r;
    logic          sgn_a;
    logic          sgn_b;
    logic          unused_bits;

    assign sgn_r = bus.result[WIDTH-1];
    assign sgn_a = bus.op1[WIDTH-1];
    assign sgn_b = bus.op2[WIDTH-1];

    // Only the operand sign bits feed the overflow terms.
    assign unused_bits = ^{bus.op1[WIDTH-2:0], bus.op2[WIDTH-2:0]};

    assign is_full  = (depth_reg == DW'(STACK_DEPTH));
    assign is_empty = (depth_reg == '0);

    // A simultaneous push and pop cancels both stack operations.
    assign push_ok   = bus.push & ~bus.pop & ~is_full;
    assign pop_ok    = bus.pop & ~bus.push & ~is_empty;
    assign err_event = (bus.push & bus.pop) | (bus.push & is_full) | (bus.pop & is_empty);

    // NONE mode never touches the flags, even with upd asserted.
    assign alu_valid = bus.upd & (bus.mode != MODE_NONE);

    // Raw ALU-derived flags before masking.
    always_comb begin
        alu_flags    = 4'b0000;
        alu_flags[2] = ~|bus.result[WIDTH-1:0];
        alu_flags[1] = sgn_r;
        case (bus.mode)
            MODE_ADD: begin
                alu_flags[3] = bus.result[WIDTH];
                alu_flags[0] = (sgn_a == sgn_b) & (sgn_r != sgn_a);
            end
            MODE_SUB: begin
                alu_flags[3] = bus.result[WIDTH];
                alu_flags[0] = (sgn_a != sgn_b) & (sgn_r != sgn_a);
            end
            MODE_LOGIC: begin
                alu_flags[3] = 1'b0;
                alu_flags[0] = 1'b0;
            end
            default: alu_flags = 4'b0000;
        endcase
    end

    // Per-flag write mask: masked-off flags keep their registered value.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_mask
            assign alu_merged[gi] = (alu_valid & bus.mask[gi]) ? alu_flags[gi] : flags_reg[gi];
        end
    endgenerate

    // Stack storage: each entry captures the pre-edge flags when it is the next free slot.
    generate
        for (gi = 0; gi < STACK_DEPTH; gi++) begin : g_stack
            logic [3:0] entry_reg;
            always_ff @(posedge clk) begin
                if (push_ok && (depth_reg == DW'(gi))) begin
                    entry_reg <= flags_reg;
                end
            end
            assign entries[gi] = entry_reg;
        end
    endgenerate

    // Select the entry below the depth pointer as the top of stack.
    always_comb begin
        stack_top = 4'b0000;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (depth_reg == DW'(i + 1)) begin
                stack_top = entries[i];
            end
        end
    end

    // Flag source priority: legal pop, then direct write, then masked ALU update.
    always_comb begin
        flags_next = alu_merged;
        if (pop_ok) begin
            flags_next = stack_top;
        end else if (bus.wr_en) begin
            flags_next = bus.wr_flags;
        end
    end

    assign depth_next     = depth_reg + DW'(push_ok) - DW'(pop_ok);
    assign stack_err_next = err_event | (stack_err_reg & ~bus.err_clr);

    // Flag, depth and sticky-error state with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_reg     <= 4'b0000;
            depth_reg     <= '0;
            stack_err_reg <= 1'b0;
        end else begin
            flags_reg     <= flags_next;
            depth_reg     <= depth_next;
            stack_err_reg <= stack_err_next;
        end
    end

    // Branch condition evaluated against the registered flags.
    always_comb begin
        cond_true_c = 1'b0;
        case (bus.cond)
            4'd0:  cond_true_c = flags_reg[2];
            4'd1:  cond_true_c = ~flags_reg[2];
            4'd2:  cond_true_c = flags_reg[3];
            4'd3:  cond_true_c = ~flags_reg[3];
            4'd4:  cond_true_c = flags_reg[1];
            4'd5:  cond_true_c = ~flags_reg[1];
            4'd6:  cond_true_c = flags_reg[0];
            4'd7:  cond_true_c = ~flags_reg[0];
            4'd8:  cond_true_c = ~flags_reg[3] & ~flags_reg[2];
            4'd9:  cond_true_c = flags_reg[3] | flags_reg[2];
            4'd10: cond_true_c = (flags_reg[1] == flags_reg[0]);
            4'd11: cond_true_c = (flags_reg[1] != flags_reg[0]);
            4'd12: cond_true_c = ~flags_reg[2] & (flags_reg[1] == flags_reg[0]);
            4'd13: cond_true_c = flags_reg[2] | (flags_reg[1] != flags_reg[0]);
            4'd14: cond_true_c = 1'b1;
            default: cond_true_c = 1'b0;
        endcase
    end

    assign bus.C         = flags_reg[3];
    assign bus.Z         = flags_reg[2];
    assign bus.N         = flags_reg[1];
    assign bus.O         = flags_reg[0];
    assign bus.cond_true = cond_true_c;
    assign bus.depth     = depth_reg;
    assign bus.full      = is_full;
    assign bus.empty     = is_empty;
    assign bus.stack_err = stack_err_reg;
endmodule
